// File: rtl/vga_digit_overlay_if.sv
// Signal bundle between the RTC register bank / VGA pins and the digit overlay renderer.
interface vga_digit_overlay_if #(
  parameter int N_ROWS = 3,
  parameter int DIGITS = 6
);
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int PAIR_W = (DIGITS > 2) ? $clog2(DIGITS / 2) : 1;

  // No valid/ready pair here: PIX_EN qualifies every clock; when it is low the
  // renderer holds all state and outputs, so a source may stretch pixels freely.
  logic                       PIX_EN;
  logic [N_ROWS*DIGITS*4-1:0] ROW_DATA;
  logic                       EDIT_EN;
  logic [ROW_W-1:0]           EDIT_ROW;
  logic [PAIR_W-1:0]          EDIT_PAIR;
  logic                       ALARM;
  logic [11:0]                COLOR_OUT;
  logic                       HS;
  logic                       VS;
  logic [9:0]                 ADDRH;
  logic [9:0]                 ADDRV;
  logic                       FRAME_TICK;

  modport master (
    output PIX_EN, ROW_DATA, EDIT_EN, EDIT_ROW, EDIT_PAIR, ALARM,
    input  COLOR_OUT, HS, VS, ADDRH, ADDRV, FRAME_TICK
  );

  modport slave (
    input  PIX_EN, ROW_DATA, EDIT_EN, EDIT_ROW, EDIT_PAIR, ALARM,
    output COLOR_OUT, HS, VS, ADDRH, ADDRV, FRAME_TICK
  );
endinterface

// File: rtl/vga_digit_overlay.sv
// VGA renderer for BCD readouts: sync generator, frame-latched glyph field with
// scaled 8x16 font, blinking edit cursor on one digit pair and blinking alarm box.
module vga_digit_overlay #(
  parameter int          N_ROWS       = 3,
  parameter int          DIGITS       = 6,
  parameter int          SCALE        = 4,
  parameter int          X0           = 96,
  parameter int          Y0           = 64,
  parameter int          ROW_PITCH    = 128,
  parameter int          PAIR_GAP     = 32,
  parameter int          AL_X         = 384,
  parameter int          AL_Y         = 384,
  parameter int          AL_SIZE      = 25,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h005,
  parameter logic [11:0] EDIT_COLOR   = 12'hF80,
  parameter logic [11:0] ALARM_COLOR  = 12'hF00,
  parameter int          H_VIS        = 640,
  parameter int          H_SYNC_START = 656,
  parameter int          H_SYNC_LEN   = 96,
  parameter int          H_TOTAL      = 800,
  parameter int          V_VIS        = 480,
  parameter int          V_SYNC_START = 490,
  parameter int          V_SYNC_LEN   = 2,
  parameter int          V_TOTAL      = 525
) (
  input logic                CLK,
  input logic                RST,
  vga_digit_overlay_if.slave bus
);
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int PAIR_W = (DIGITS > 2) ? $clog2(DIGITS / 2) : 1;
  localparam int CELL_W = 8 * SCALE;
  localparam int CELL_H = 16 * SCALE;

  // One 128-bit word per glyph; row 0 is the top byte, bit 7 of each byte the leftmost column.
  localparam logic [127:0] FONT [10] = '{
    128'h0000_3C66_666E_7666_6666_6666_3C00_0000,
    128'h0000_1838_7818_1818_1818_1818_7E00_0000,
    128'h0000_3C66_0606_0C18_3060_6066_7E00_0000,
    128'h0000_3C66_0606_1C06_0606_0666_3C00_0000,
    128'h0000_0C1C_3C6C_CCFE_0C0C_0C0C_1E00_0000,
    128'h0000_7E60_6060_7C06_0606_0666_3C00_0000,
    128'h0000_3C66_6060_7C66_6666_6666_3C00_0000,
    128'h0000_7E66_0606_0C18_1818_1818_1800_0000,
    128'h0000_3C66_6666_3C66_6666_6666_3C00_0000,
    128'h0000_3C66_6666_663E_0606_0666_3C00_0000
  };

  logic [9:0]                 h, v;
  logic                       h_last, v_last, frame_tick;
  logic [N_ROWS*DIGITS*4-1:0] row_lat;
  logic                       edit_en_lat, alarm_lat, phase;
  logic [ROW_W-1:0]           edit_row_lat;
  logic [PAIR_W-1:0]          edit_pair_lat;
  logic [7:0]                 frame_cnt;

  assign h_last     = (h == 10'(H_TOTAL - 1));
  assign v_last     = (v == 10'(V_TOTAL - 1));
  assign frame_tick = bus.PIX_EN && h_last && v_last;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      h <= '0;
      v <= '0;
    end else if (bus.PIX_EN) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // Inputs are sampled only at the frame boundary so a frame never shows mixed data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_lat       <= '0;
      edit_en_lat   <= 1'b0;
      edit_row_lat  <= '0;
      edit_pair_lat <= '0;
      alarm_lat     <= 1'b0;
      frame_cnt     <= '0;
      phase         <= 1'b0;
    end else if (frame_tick) begin
      row_lat       <= bus.ROW_DATA;
      edit_en_lat   <= bus.EDIT_EN && (int'(bus.EDIT_ROW) < N_ROWS)
                       && (int'(bus.EDIT_PAIR) < DIGITS / 2);
      edit_row_lat  <= bus.EDIT_ROW;
      edit_pair_lat <= bus.EDIT_PAIR;
      alarm_lat     <= bus.ALARM;
      if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  int         hx, vy, left, top;
  logic       hit, in_pair, in_box, visible, hs0, vs0;
  logic [3:0] digit, gy;
  logic [2:0] gx;

  always_comb begin
    hx      = int'(h);
    vy      = int'(v);
    left    = 0;
    top     = 0;
    hit     = 1'b0;
    in_pair = 1'b0;
    digit   = 4'd0;
    gx      = 3'd0;
    gy      = 4'd0;
    for (int r = 0; r < N_ROWS; r++) begin
      for (int d = 0; d < DIGITS; d++) begin
        left = X0 + d * CELL_W + (d / 2) * PAIR_GAP;
        top  = Y0 + r * ROW_PITCH;
        if (hx >= left && hx < left + CELL_W && vy >= top && vy < top + CELL_H) begin
          hit     = 1'b1;
          digit   = row_lat[(r * DIGITS + DIGITS - 1 - d) * 4 +: 4];
          gx      = 3'((hx - left) / SCALE);
          gy      = 4'((vy - top) / SCALE);
          in_pair = edit_en_lat && (int'(edit_row_lat) == r) && (int'(edit_pair_lat) == d / 2);
        end
      end
    end
    in_box  = hx >= AL_X && hx < AL_X + AL_SIZE && vy >= AL_Y && vy < AL_Y + AL_SIZE;
    visible = hx < H_VIS && vy < V_VIS;
    hs0     = !(hx >= H_SYNC_START && hx < H_SYNC_START + H_SYNC_LEN);
    vs0     = !(vy >= V_SYNC_START && vy < V_SYNC_START + V_SYNC_LEN);
  end

  logic       vis1, glyph1, box1, edit1, hs1, vs1;
  logic [3:0] digit1, gy1;
  logic [2:0] gx1;

  // Non-decimal nibbles never reach the font lookup; they render as background.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vis1   <= 1'b0;
      glyph1 <= 1'b0;
      box1   <= 1'b0;
      edit1  <= 1'b0;
      digit1 <= 4'd0;
      gx1    <= 3'd0;
      gy1    <= 4'd0;
      hs1    <= 1'b1;
      vs1    <= 1'b1;
    end else if (bus.PIX_EN) begin
      vis1   <= visible;
      glyph1 <= hit && (digit < 4'd10);
      box1   <= in_box && alarm_lat && phase;
      edit1  <= in_pair && phase;
      digit1 <= (hit && (digit < 4'd10)) ? digit : 4'd0;
      gx1    <= gx;
      gy1    <= gy;
      hs1    <= hs0;
      vs1    <= vs0;
    end
  end

  logic        font_bit;
  logic [11:0] color_next, color_q;
  logic        hs_q, vs_q;

  assign font_bit = FONT[digit1][{~gy1, ~gx1}];

  always_comb begin
    color_next = BG_COLOR;
    if (!vis1)                 color_next = 12'h000;
    else if (box1)             color_next = ALARM_COLOR;
    else if (glyph1 && font_bit) color_next = edit1 ? EDIT_COLOR : FG_COLOR;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      color_q <= 12'h000;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else if (bus.PIX_EN) begin
      color_q <= color_next;
      hs_q    <= hs1;
      vs_q    <= vs1;
    end
  end

  assign bus.COLOR_OUT  = color_q;
  assign bus.HS         = hs_q;
  assign bus.VS         = vs_q;
  assign bus.ADDRH      = h;
  assign bus.ADDRV      = v;
  assign bus.FRAME_TICK = frame_tick;
endmodule

// File: tb/tb_vga_digit_overlay.sv
// Directed bench for vga_digit_overlay on a shrunken raster (130x108, SCALE 2) so several frames fit in a short run.
module tb_vga_digit_overlay;
  localparam int H_TOTAL = 130;
  localparam int V_TOTAL = 108;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
  localparam int BUDGET  = 2 * FRAME + 16;

  localparam logic [31:0] FG    = 32'hFFF;
  localparam logic [31:0] BG    = 32'h005;
  localparam logic [31:0] EDIT  = 32'hF80;
  localparam logic [31:0] ALRM  = 32'hF00;
  localparam logic [31:0] BLACK = 32'h000;

  localparam logic [71:0] DATA_A = 72'h135790_A52780_123456;
  localparam logic [71:0] DATA_B = 72'h135790_A52780_987654;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_cyc = 0, n_hs = 0, n_vs = 0, n_tick = 0;
  int   s_cyc, s_hs, s_vs, s_tick;

  vga_digit_overlay_if #(.N_ROWS(3), .DIGITS(6)) bus_if ();

  vga_digit_overlay #(
    .N_ROWS(3), .DIGITS(6), .SCALE(2), .X0(4), .Y0(2), .ROW_PITCH(34), .PAIR_GAP(2),
    .AL_X(108), .AL_Y(4), .AL_SIZE(5), .BLINK_FRAMES(2),
    .H_VIS(116), .H_SYNC_START(120), .H_SYNC_LEN(8), .H_TOTAL(H_TOTAL),
    .V_VIS(104), .V_SYNC_START(105), .V_SYNC_LEN(2), .V_TOTAL(V_TOTAL)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST) begin
      n_cyc++;
      if (!bus_if.HS)        n_hs++;
      if (!bus_if.VS)        n_vs++;
      if (bus_if.FRAME_TICK) n_tick++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits until pixel (x,y) has reached COLOR_OUT (two enabled ticks later), then compares.
  task automatic check_pix(input string tag, input int x, input int y, input logic [31:0] exp);
    logic found;
    found = 1'b0;
    for (int i = 0; i < BUDGET && !found; i++) begin
      @(negedge CLK);
      if (int'(bus_if.ADDRH) == x + 2 && int'(bus_if.ADDRV) == y) found = 1'b1;
    end
    if (!found) check_eq({tag, "_timeout"}, 32'(found), 32'd1);
    else        check_eq(tag, 32'(bus_if.COLOR_OUT), exp);
  endtask

  // Returns just after the edge that ends the FRAME_TICK cycle (first pixel of the new frame).
  task automatic wait_frame(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < BUDGET && !found; i++) begin
      @(negedge CLK);
      if (bus_if.FRAME_TICK) found = 1'b1;
    end
    if (!found) check_eq({tag, "_timeout"}, 32'(found), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] hold_exp [5] = '{ALRM, ALRM, ALRM, BG, BG};

  initial begin
    bus_if.PIX_EN    = 1'b1;
    bus_if.ROW_DATA  = DATA_A;
    bus_if.EDIT_EN   = 1'b1;
    bus_if.EDIT_ROW  = 2'd1;
    bus_if.EDIT_PAIR = 2'd2;
    bus_if.ALARM     = 1'b1;
    #1 RST = 1'b0;
    #2;
    check_eq("rst_addrh", 32'(bus_if.ADDRH), 32'd0);
    check_eq("rst_addrv", 32'(bus_if.ADDRV), 32'd0);
    check_eq("rst_hs", 32'(bus_if.HS), 32'd1);
    check_eq("rst_vs", 32'(bus_if.VS), 32'd1);
    check_eq("rst_color", 32'(bus_if.COLOR_OUT), BLACK);
    check_eq("rst_tick", 32'(bus_if.FRAME_TICK), 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // Frame 0: nothing latched yet, every digit shows "0", alarm off.
    check_pix("f0_d0_col0", 4, 6, BG);
    check_pix("f0_d0_zero", 8, 6, FG);
    check_pix("f0_alarm_off", 110, 6, BG);
    wait_frame("tick1");
    s_cyc = n_cyc; s_hs = n_hs; s_vs = n_vs; s_tick = n_tick;

    // Frame 1: DATA_A latched, blink phase 0.
    check_pix("f1_origin_bg", 0, 0, BG);
    check_pix("f1_one_col0", 4, 6, BG);
    check_pix("f1_one_stem", 10, 6, FG);
    check_pix("f1_two_top", 24, 6, FG);
    check_pix("f1_alarm_ph0", 110, 6, BG);
    bus_if.ROW_DATA = DATA_B;
    check_pix("f1_offscreen", 120, 10, BLACK);
    check_pix("f1_one_base", 7, 26, FG);
    check_pix("f1_one_base_edge", 18, 26, BG);
    check_pix("f1_seven", 56, 40, FG);
    check_pix("f1_edit_d4_ph0", 76, 40, FG);
    check_pix("f1_edit_d5_ph0", 92, 40, FG);
    check_pix("f1_blank_nibble", 10, 60, BG);
    wait_frame("tick2");

    // Frame 2: DATA_B latched, phase 1 lights cursor and alarm.
    check_pix("f2_nine_col0", 4, 6, BG);
    check_pix("f2_nine_top", 8, 6, FG);
    check_pix("f2_alarm_ph1", 110, 6, ALRM);
    check_pix("f2_seven_noedit", 56, 40, FG);
    check_pix("f2_edit_d4_ph1", 76, 40, EDIT);
    check_pix("f2_edit_d5_ph1", 92, 40, EDIT);
    wait_frame("tick3");
    check_eq("two_frame_cycles", 32'(n_cyc - s_cyc), 32'(2 * FRAME));
    check_eq("two_frame_hs_low", 32'(n_hs - s_hs), 32'(2 * V_TOTAL * 8));
    check_eq("two_frame_vs_low", 32'(n_vs - s_vs), 32'(2 * 2 * H_TOTAL));
    check_eq("two_frame_ticks", 32'(n_tick - s_tick), 32'd2);

    // Frame 3: half-period is two frames, so phase is still 1.
    check_pix("f3_alarm_ph1", 110, 6, ALRM);
    for (int k = 0; k < 5; k++) begin
      bus_if.PIX_EN = 1'b0;
      repeat (3) @(negedge CLK);
      check_eq("hold_addrh", 32'(bus_if.ADDRH), 32'(112 + k));
      check_eq("hold_color", 32'(bus_if.COLOR_OUT), hold_exp[k]);
      bus_if.PIX_EN = 1'b1;
      @(negedge CLK);
    end
    check_eq("after_hold_addrh", 32'(bus_if.ADDRH), 32'd117);
    check_eq("after_hold_color", 32'(bus_if.COLOR_OUT), BG);

    // Asynchronous reset mid-line, observed before the next clock edge.
    #2 RST = 1'b0;
    #1;
    check_eq("async_addrh", 32'(bus_if.ADDRH), 32'd0);
    check_eq("async_addrv", 32'(bus_if.ADDRV), 32'd0);
    check_eq("async_color", 32'(bus_if.COLOR_OUT), BLACK);
    check_eq("async_hs", 32'(bus_if.HS), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("restart_addrh", 32'(bus_if.ADDRH), 32'd1);
    check_eq("restart_addrv", 32'(bus_if.ADDRV), 32'd0);
    check_pix("rst_latch_zero", 8, 6, FG);
    check_pix("rst_alarm_clear", 110, 6, BG);
    check_pix("rst_edit_clear", 76, 40, FG);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
